// File: rtl/amax10_qsys_i2c_pkg.sv
// rtl/amax10_qsys_i2c_pkg.sv - shared state encoding and bank constants for the I2C register target
package amax10_qsys_i2c_pkg;

    typedef enum logic [3:0] {
        IDLE,
        DEVADDR,
        DEVACK,
        REGADDR,
        REGACK,
        WRDATA,
        WRACK,
        RDDATA,
        RDACK
    } i2c_state_e;

    localparam int         BANK_DEPTH   = 16;
    localparam logic [7:0] OOR_RD_VALUE = 8'hFF;

    function automatic logic ptr_in_bank(input logic [7:0] ptr);
        return ptr < 8'(BANK_DEPTH);
    endfunction

endpackage

// File: rtl/amax10_qsys_i2c_sync.sv
// rtl/amax10_qsys_i2c_sync.sv - SCL/SDA synchronizers with SCL edge and START/STOP detection
module amax10_qsys_i2c_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic scl_in,
    input  logic sda_in,
    output logic sda_s,
    output logic scl_rise,
    output logic scl_fall,
    output logic start_det,
    output logic stop_det
);

    logic [SYNC_STAGES-1:0] scl_sync_q, scl_sync_d;
    logic [SYNC_STAGES-1:0] sda_sync_q, sda_sync_d;
    logic                   scl_prev_q, scl_prev_d;
    logic                   sda_prev_q, sda_prev_d;
    logic                   scl_s;

    always_comb begin
        scl_sync_d = {scl_sync_q[SYNC_STAGES-2:0], scl_in};
        sda_sync_d = {sda_sync_q[SYNC_STAGES-2:0], sda_in};
        scl_prev_d = scl_sync_q[SYNC_STAGES-1];
        sda_prev_d = sda_sync_q[SYNC_STAGES-1];
    end

    // Idle bus level is high, so a reset never manufactures an edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            scl_sync_q <= '1;
            sda_sync_q <= '1;
            scl_prev_q <= 1'b1;
            sda_prev_q <= 1'b1;
        end else begin
            scl_sync_q <= scl_sync_d;
            sda_sync_q <= sda_sync_d;
            scl_prev_q <= scl_prev_d;
            sda_prev_q <= sda_prev_d;
        end
    end

    assign scl_s     = scl_sync_q[SYNC_STAGES-1];
    assign sda_s     = sda_sync_q[SYNC_STAGES-1];
    assign scl_rise  = scl_s & ~scl_prev_q;
    assign scl_fall  = ~scl_s & scl_prev_q;
    assign start_det = scl_s & scl_prev_q & sda_prev_q & ~sda_s;
    assign stop_det  = scl_s & scl_prev_q & ~sda_prev_q & sda_s;

endmodule

// File: rtl/amax10_qsys_i2c_target.sv
// rtl/amax10_qsys_i2c_target.sv - I2C target with 16x8 register bank and host read port
// Define I2C_TGT_AUTOINC_EN to advance the register pointer after each written or ACKed read byte.
module amax10_qsys_i2c_target
    import amax10_qsys_i2c_pkg::*;
#(
    parameter logic [6:0] DEV_ADDR    = 7'h39,
    parameter int         SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       scl_in,
    input  logic       sda_in,
    output logic       sda_oe,
    input  logic [3:0] reg_rd_addr,
    output logic [7:0] reg_rd_data,
    output logic       wr_strobe,
    output logic [7:0] wr_addr,
    output logic [7:0] wr_data,
    output logic       busy
);

`ifdef I2C_TGT_AUTOINC_EN
    localparam logic AUTOINC = 1'b1;
`else
    localparam logic AUTOINC = 1'b0;
`endif

    logic sda_s, scl_rise, scl_fall, start_det, stop_det;

    amax10_qsys_i2c_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk      (clk),
        .reset    (reset),
        .scl_in   (scl_in),
        .sda_in   (sda_in),
        .sda_s    (sda_s),
        .scl_rise (scl_rise),
        .scl_fall (scl_fall),
        .start_det(start_det),
        .stop_det (stop_det)
    );

    i2c_state_e state_q, state_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic       done_q, done_d;
    logic [7:0] shreg_q, shreg_d;
    logic [7:0] ptr_q, ptr_d;
    logic       rw_q, rw_d;
    logic       sda_oe_q, sda_oe_d;
    logic       busy_q, busy_d;
    logic       wr_strobe_q, wr_strobe_d;
    logic [7:0] wr_addr_q, wr_addr_d;
    logic [7:0] wr_data_q, wr_data_d;
    logic [7:0] rd_data_q, rd_data_d;
    logic [7:0] bank_q [BANK_DEPTH];
    logic [7:0] bank_d [BANK_DEPTH];
    logic [7:0] rd_byte;

    // Bits are sampled on SCL rise; every SDA change and state hand-off happens on SCL fall.
    always_comb begin
        rd_byte     = ptr_in_bank(ptr_q) ? bank_q[ptr_q[3:0]] : OOR_RD_VALUE;
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        done_d      = done_q;
        shreg_d     = shreg_q;
        ptr_d       = ptr_q;
        rw_d        = rw_q;
        sda_oe_d    = sda_oe_q;
        busy_d      = busy_q;
        wr_strobe_d = 1'b0;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;
        bank_d      = bank_q;
        rd_data_d   = bank_q[reg_rd_addr];

        if (stop_det) begin
            state_d  = IDLE;
            sda_oe_d = 1'b0;
            busy_d   = 1'b0;
            done_d   = 1'b0;
        end else if (start_det) begin
            state_d   = DEVADDR;
            bit_cnt_d = '0;
            done_d    = 1'b0;
            sda_oe_d  = 1'b0;
        end else if (scl_rise) begin
            case (state_q)
                DEVADDR, REGADDR, WRDATA: begin
                    shreg_d   = {shreg_q[6:0], sda_s};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    done_d    = (bit_cnt_q == 3'd7);
                end
                RDDATA: begin
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    done_d    = (bit_cnt_q == 3'd7);
                end
                RDACK: begin
                    if (sda_s) begin
                        state_d = IDLE;
                        busy_d  = 1'b0;
                    end else if (AUTOINC) begin
                        ptr_d = ptr_q + 8'd1;
                    end
                end
                default: ;
            endcase
        end else if (scl_fall) begin
            case (state_q)
                DEVADDR: begin
                    if (done_q) begin
                        done_d = 1'b0;
                        if (shreg_q[7:1] == DEV_ADDR) begin
                            state_d  = DEVACK;
                            rw_d     = shreg_q[0];
                            sda_oe_d = 1'b1;
                            busy_d   = 1'b1;
                        end else begin
                            state_d = IDLE;
                            busy_d  = 1'b0;
                        end
                    end
                end
                DEVACK: begin
                    bit_cnt_d = '0;
                    if (rw_q) begin
                        state_d  = RDDATA;
                        shreg_d  = rd_byte;
                        sda_oe_d = ~rd_byte[7];
                    end else begin
                        state_d  = REGADDR;
                        sda_oe_d = 1'b0;
                    end
                end
                REGADDR: begin
                    if (done_q) begin
                        done_d   = 1'b0;
                        state_d  = REGACK;
                        ptr_d    = shreg_q;
                        sda_oe_d = 1'b1;
                    end
                end
                REGACK: begin
                    state_d   = WRDATA;
                    bit_cnt_d = '0;
                    sda_oe_d  = 1'b0;
                end
                WRDATA: begin
                    if (done_q) begin
                        done_d      = 1'b0;
                        state_d     = WRACK;
                        sda_oe_d    = 1'b1;
                        wr_strobe_d = 1'b1;
                        wr_addr_d   = ptr_q;
                        wr_data_d   = shreg_q;
                        if (ptr_in_bank(ptr_q)) begin
                            bank_d[ptr_q[3:0]] = shreg_q;
                        end
                        if (AUTOINC) begin
                            ptr_d = ptr_q + 8'd1;
                        end
                    end
                end
                WRACK: begin
                    state_d   = WRDATA;
                    bit_cnt_d = '0;
                    sda_oe_d  = 1'b0;
                end
                RDDATA: begin
                    if (done_q) begin
                        done_d   = 1'b0;
                        state_d  = RDACK;
                        sda_oe_d = 1'b0;
                    end else begin
                        shreg_d  = {shreg_q[6:0], 1'b0};
                        sda_oe_d = ~shreg_q[6];
                    end
                end
                RDACK: begin
                    // Only reached after an ACK; a NACK already left on the rising edge.
                    state_d   = RDDATA;
                    bit_cnt_d = '0;
                    shreg_d   = rd_byte;
                    sda_oe_d  = ~rd_byte[7];
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            bit_cnt_q   <= '0;
            done_q      <= 1'b0;
            shreg_q     <= '0;
            ptr_q       <= '0;
            rw_q        <= 1'b0;
            sda_oe_q    <= 1'b0;
            busy_q      <= 1'b0;
            wr_strobe_q <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            rd_data_q   <= '0;
            for (int i = 0; i < BANK_DEPTH; i++) begin
                bank_q[i] <= 8'h00;
            end
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            done_q      <= done_d;
            shreg_q     <= shreg_d;
            ptr_q       <= ptr_d;
            rw_q        <= rw_d;
            sda_oe_q    <= sda_oe_d;
            busy_q      <= busy_d;
            wr_strobe_q <= wr_strobe_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
            rd_data_q   <= rd_data_d;
            bank_q      <= bank_d;
        end
    end

    assign sda_oe      = sda_oe_q;
    assign busy        = busy_q;
    assign wr_strobe   = wr_strobe_q;
    assign wr_addr     = wr_addr_q;
    assign wr_data     = wr_data_q;
    assign reg_rd_data = rd_data_q;

endmodule
